phy_rx_lanes: RTL

Parametrised multi-lane PHY receiver running on the single bit-rate clock. For each of `LANES` serial inputs it shifts in bits MSB first and finds byte alignment on a comma symbol. It then locks after `LOCK_COUNT` consecutive aligned commas and emits deframed bytes with a per-lane valid. It succeeds the fixed two-lane, three-clock receiver: lane count, symbol width and sync symbols are parameters, and the new lock state machine and lane-status outputs replace the divided clocks.

---
 rtl/phy_rx_lanes.sv | 123 ++++++++++++
 1 files changed

// File: rtl/phy_rx_lanes.sv
// Multi-lane serial PHY receiver: per-lane comma alignment, lock FSM and byte deframing.
// Optional PHY_RX_RELOCK_EN: a misaligned comma while ACTIVE drops the lane back to SEARCH.
module phy_rx_lanes #(
   parameter int unsigned      LANES      = 2,
   parameter int unsigned      WIDTH      = 8,
   parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
   parameter logic [WIDTH-1:0] IDLE_SYM   = 8'h7C,
   parameter int unsigned      LOCK_COUNT = 4
) (
   input  logic                   clk_8f,
   input  logic                   reset,
   input  logic [LANES-1:0]       data_in,
   output logic [LANES*WIDTH-1:0] data_out,
   output logic [LANES-1:0]       valid_out,
   output logic [LANES-1:0]       active_out,
   output logic                   all_active
);

   localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned CMA_W = $clog2(LOCK_COUNT + 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
   localparam logic [CMA_W-1:0] LOCK_VAL = CMA_W'(LOCK_COUNT);

   typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_t;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      state_t           state_q, state_d;
      // Only the low WIDTH-1 bits of the shift register feed the next candidate.
      logic [WIDTH-2:0] sr_q;
      logic [WIDTH-1:0] cand_c;
      logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
      logic [CMA_W-1:0] comma_cnt_q, comma_cnt_d, comma_inc_c;
      logic [WIDTH-1:0] data_q, data_d;
      logic             valid_q, valid_d;
      logic             active_q, active_d;
      logic             byte_done_c;

      assign cand_c      = {sr_q, data_in[i]};
      assign byte_done_c = (bit_cnt_q == LAST_BIT);
      assign comma_inc_c = comma_cnt_q + CMA_W'(1);

      always_ff @(posedge clk_8f or negedge reset) begin
         if (!reset) begin
            state_q     <= SEARCH;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            active_q    <= 1'b0;
         end else begin
            state_q     <= state_d;
            sr_q        <= cand_c[WIDTH-2:0];
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            active_q    <= active_d;
         end
      end

      // Lock FSM: sliding comma search, aligned comma counting, then deframing.
      always_comb begin
         state_d     = state_q;
         bit_cnt_d   = bit_cnt_q;
         comma_cnt_d = comma_cnt_q;
         data_d      = data_q;
         valid_d     = valid_q;
         unique case (state_q)
            SEARCH: begin
               if (cand_c == COMMA) begin
                  bit_cnt_d   = '0;
                  comma_cnt_d = CMA_W'(1);
                  state_d     = (LOCK_COUNT == 1) ? ACTIVE : ALIGN;
               end
            end
            ALIGN: begin
               bit_cnt_d = byte_done_c ? '0 : bit_cnt_q + BIT_W'(1);
               if (byte_done_c) begin
                  if (cand_c == COMMA) begin
                     comma_cnt_d = comma_inc_c;
                     if (comma_inc_c == LOCK_VAL) state_d = ACTIVE;
                  end else begin
                     comma_cnt_d = '0;
                     state_d     = SEARCH;
                  end
               end
            end
            ACTIVE: begin
               bit_cnt_d = byte_done_c ? '0 : bit_cnt_q + BIT_W'(1);
               if (byte_done_c) begin
                  if (cand_c != COMMA && cand_c != IDLE_SYM) begin
                     data_d  = cand_c;
                     valid_d = 1'b1;
                  end else begin
                     valid_d = 1'b0;
                  end
               end
`ifdef PHY_RX_RELOCK_EN
               else if (cand_c == COMMA) begin
                  state_d     = SEARCH;
                  valid_d     = 1'b0;
                  comma_cnt_d = '0;
               end
`endif
            end
            default: state_d = SEARCH;
         endcase
         active_d = (state_d == ACTIVE);
      end

      assign data_out[i*WIDTH +: WIDTH] = data_q;
      assign valid_out[i]               = valid_q;
      assign active_out[i]              = active_q;
   end

   // Lags the lane status by one cycle.
   always_ff @(posedge clk_8f or negedge reset) begin
      if (!reset) all_active <= 1'b0;
      else        all_active <= &active_out;
   end

endmodule
